addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined signed add/subtract unit for FFT butterfly datapaths; next generation of the single-cycle 24-bit registered ripple adder.
- The carry chain is split into SEGS registered segments, so the adder closes timing at wider WIDTH.
- Adds a valid/enable pipeline, per-sample add/sub select, optional divide-by-2 scaling (butterfly stage scaling) and synchronous flush.
- Sits between the twiddle multiplier outputs and the butterfly output registers; one instance per real/imag rail.

Parameters:
- WIDTH, 24, operand width in bits, two's complement signed.
- SEGS, 2, number of carry-chain pipeline segments; legal range 1..WIDTH; latency = SEGS cycles.
- SEG_W, derived = ceil(WIDTH/SEGS), segment width; the top segment takes the remainder bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  pipeline advance; 0 = every register holds.
- flush  input  1  synchronous; clears all valid bits.
- in_valid  input  1  sample qualifier for a/b/sub/scale.
- a  input  WIDTH  signed operand A.
- b  input  WIDTH  signed operand B.
- sub  input  1  0: A+B, 1: A-B.
- scale  input  1  1: result arithmetically shifted right by 1 (truncate toward -inf).
- out  output  WIDTH+1  signed result, registered.
- out_valid  output  1  out qualifier.

Behaviour:
- Reset (rst_n low, asynchronous): out=0, out_valid=0, all internal segment/carry/skew/valid/ctrl registers=0. Release is synchronous to clk; the first capture happens on the first rising edge with rst_n high.
- Arithmetic: full = sext(a,WIDTH+1) + (sub ? ~sext(b,WIDTH+1) + 1 : sext(b,WIDTH+1)). Exact; no overflow possible.
- Inversion and +1 are implemented as b^sub with carry-in = sub at segment 0.
- If scale=1: out = {full[WIDTH], full[WIDTH:1]}. Otherwise out = full.
- Segmentation: stage k (0..SEGS-1) adds bits of segment k plus the carry registered from stage k-1.
  - Operand bits of higher segments pass through input skew registers (k cycles deep).
  - Result bits of lower segments pass through output deskew registers, so all bits of one sample emerge together.
  - The sign/top bit (full[WIDTH]) is formed in the last stage from the sign-extended top bits and the final carry.
- sub and scale travel down the pipeline with their sample.
- Latency: a sample presented with in_valid=1 on an en=1 edge appears on out with out_valid=1 exactly SEGS en=1 edges later. Throughput is 1 sample per cycle, back-to-back, with sub/scale free to change every cycle.
- en=0: no register changes, including out/out_valid (stall holds output). in_valid is ignored on that edge.
- flush=1 on an edge (any en): all valid bits become 0, so out_valid=0 on the next cycle. Data registers may update or hold; they are don't-care when invalid.
- flush and in_valid on the same edge: the flush wins and the sample is dropped.
- Data registers advance on every en=1 edge regardless of valid; out is only meaningful when out_valid=1.
- rst_n asserted mid-stream: all in-flight samples are lost immediately. No partial output afterwards.
- SEGS=1: degenerates to a single registered adder with latency 1.

Decomposition:
- Shared package addsub_pkg: function seg_w(WIDTH,SEGS) and localparam SEG_W. The FFT-wide localparam DATA_W=24 also lives there.
- One sub-module: addsub_seg, a SEG_W-bit ripple segment with carry-in/carry-out. It is generate-instantiated SEGS times; registers stay in the parent.

Test Plan (WIDTH=24, SEGS=2, SEG_W=12 unless stated):
- Basic add: a=0x000001, b=0x000001, sub=0, scale=0, in_valid=1 for one cycle -> out=0x0000002, out_valid=1 exactly 2 cycles later, then 0.
- Positive extreme: a=0x7FFFFF + b=0x000001 -> out=0x0800000 (+8388608). Negative extreme: a=0x800000 - b=0x000001 -> out=0x17FFFFF (-8388609).
- Segment-boundary carry, streamed every cycle:
  - 0x000FFF+0x000001 -> 0x0001000.
  - 0x000000-0x000001 -> 0x1FFFFFF.
  - 0x000FFF-0x000FFF -> 0x0000000.
  - Outputs arrive in order on consecutive cycles.
- Scaling: 3+2 scale=1 -> 0x0000002; (-3=0xFFFFFD)+0 scale=1 -> 0x1FFFFFE (-2); mixed with scale=0 samples back-to-back.
- Stall/flush:
  - en=0 for 3 cycles with 2 samples in flight -> out/out_valid frozen; delivery resumes unchanged after en=1.
  - flush=1 with 2 in flight -> no out_valid for either sample.
- Reset/params:
  - rst_n pulsed low mid-stream -> out=0, out_valid=0 asynchronously; no stale samples emerge.
  - Rerun the random compare vs. golden model for (WIDTH,SEGS) = (24,1), (24,3), (16,4), (25,2).

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and segmentation helpers for the pipelined add/sub datapath.
package addsub_pkg;

  // Sample width used across the FFT datapath.
  localparam int DATA_W   = 24;
  localparam int DEF_SEGS = 2;

  // Nominal segment width: ceil(width / segs).
  function automatic int seg_w(input int width, input int segs);
    return (width + segs - 1) / segs;
  endfunction

  // Lowest bit of segment k (k = segs gives width). Segments are seg_w wide
  // with the top one taking the remainder; the clamp keeps every segment at
  // least one bit wide for awkward width/segs combinations.
  function automatic int seg_lo(input int width, input int segs, input int k);
    int lo;
    int cap;
    lo  = k * seg_w(width, segs);
    cap = width - (segs - k);
    return (lo < cap) ? lo : cap;
  endfunction

  localparam int SEG_W = seg_w(DATA_W, DEF_SEGS);

endpackage

// File: rtl/addsub_seg.sv
// One ripple segment of the split carry chain: sum = a + b + cin.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int W = SEG_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined signed add/subtract with per-sample sub/scale, stall and flush.
// The carry chain is cut into SEGS registered segments; stage k adds its own
// slice plus the carry from stage k-1, while untouched operand bits ride
// along (skew) and finished result bits ride along (deskew) in the same
// full-width stage registers so a sample's bits leave together.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SEGS  = DEF_SEGS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             scale,
  output logic [WIDTH:0]   out,
  output logic             out_valid
);

  logic [WIDTH:0] out_reg;
  logic           out_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SEGS; gi++) begin : g_stage
      localparam int LO = seg_lo(WIDTH, SEGS, gi);
      localparam int HI = seg_lo(WIDTH, SEGS, gi + 1) - 1;

      // Stage inputs: ports for stage 0, previous stage registers otherwise.
      logic [WIDTH-1:0] a_st;
      logic [WIDTH-1:0] b_st;
      logic [WIDTH-1:0] sum_st;
      logic             carry_st;
      logic             valid_st;
      logic             sub_st;
      logic             scale_st;

      logic [HI-LO:0]   seg_sum;
      logic             seg_cout;
      logic [WIDTH-1:0] sum_next;

      if (gi == 0) begin : g_head
        // Subtraction is b inverted with a carry-in of one into segment 0.
        assign a_st     = a;
        assign b_st     = b ^ {WIDTH{sub}};
        assign sum_st   = '0;
        assign carry_st = sub;
        assign valid_st = in_valid;
        assign sub_st   = sub;
        assign scale_st = scale;
      end else begin : g_body
        assign a_st     = g_stage[gi-1].g_mid.a_reg;
        assign b_st     = g_stage[gi-1].g_mid.b_reg;
        assign sum_st   = g_stage[gi-1].g_mid.sum_reg;
        assign carry_st = g_stage[gi-1].g_mid.carry_reg;
        assign valid_st = g_stage[gi-1].g_mid.valid_reg;
        assign sub_st   = g_stage[gi-1].g_mid.sub_reg;
        assign scale_st = g_stage[gi-1].g_mid.scale_reg;
      end

      addsub_seg #(.W(HI - LO + 1)) u_seg (
        .a    (a_st[HI:LO]),
        .b    (b_st[HI:LO]),
        .cin  (carry_st),
        .sum  (seg_sum),
        .cout (seg_cout)
      );

      // Merge this segment's result into the bits finished by earlier stages.
      always_comb begin
        sum_next        = sum_st;
        sum_next[HI:LO] = seg_sum;
      end

      if (gi < SEGS - 1) begin : g_mid
        logic [WIDTH-1:0] a_reg;
        logic [WIDTH-1:0] b_reg;
        logic [WIDTH-1:0] sum_reg;
        logic             carry_reg;
        logic             valid_reg;
        logic             sub_reg;
        logic             scale_reg;

        // Intermediate stage register; flush clears valid even while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            valid_reg <= 1'b0;
            sub_reg   <= 1'b0;
            scale_reg <= 1'b0;
          end else begin
            if (en) begin
              a_reg     <= a_st;
              b_reg     <= b_st;
              sum_reg   <= sum_next;
              carry_reg <= seg_cout;
              sub_reg   <= sub_st;
              scale_reg <= scale_st;
            end
            if (flush) begin
              valid_reg <= 1'b0;
            end else if (en) begin
              valid_reg <= valid_st;
            end
          end
        end
      end else begin : g_last
        logic           top_bit;
        logic [WIDTH:0] full;
        logic [WIDTH:0] out_next;

        // Sign bit from the sign-extended operand tops plus the final carry.
        assign top_bit  = a_st[WIDTH-1] ^ b_st[WIDTH-1] ^ seg_cout;
        assign full     = {top_bit, sum_next};
        assign out_next = scale_st ? {top_bit, full[WIDTH:1]} : full;

        // Output register; flush clears valid even while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
          end else begin
            if (en) begin
              out_reg <= out_next;
            end
            if (flush) begin
              out_valid_reg <= 1'b0;
            end else if (en) begin
              out_valid_reg <= valid_st;
            end
          end
        end
      end
    end
  endgenerate

  assign out       = out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed tests on the default (24,2) instance plus a random golden-model
// comparison across several WIDTH/SEGS configurations.
module tb_addsub_pipe;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic        flush    = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub      = 1'b0;
  logic        scale    = 1'b0;
  logic [24:0] a_bus    = '0;
  logic [24:0] b_bus    = '0;

  logic [24:0] out0;
  logic [24:0] out1;
  logic [24:0] out2;
  logic [16:0] out3;
  logic [25:0] out4;
  logic [4:0]  ovs;
  logic [25:0] o_arr [5];

  int n_checks = 0;
  int n_pass   = 0;

  int wd  [5] = '{24, 24, 24, 16, 25};
  int lat [5] = '{2, 1, 3, 4, 2};

  logic [24:0] h_a  [0:63];
  logic [24:0] h_b  [0:63];
  logic        h_s  [0:63];
  logic        h_sc [0:63];
  logic        h_v  [0:63];

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(24), .SEGS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .a(a_bus[23:0]), .b(b_bus[23:0]), .sub(sub), .scale(scale),
    .out(out0), .out_valid(ovs[0]));
  addsub_pipe #(.WIDTH(24), .SEGS(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .a(a_bus[23:0]), .b(b_bus[23:0]), .sub(sub), .scale(scale),
    .out(out1), .out_valid(ovs[1]));
  addsub_pipe #(.WIDTH(24), .SEGS(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .a(a_bus[23:0]), .b(b_bus[23:0]), .sub(sub), .scale(scale),
    .out(out2), .out_valid(ovs[2]));
  addsub_pipe #(.WIDTH(16), .SEGS(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .a(a_bus[15:0]), .b(b_bus[15:0]), .sub(sub), .scale(scale),
    .out(out3), .out_valid(ovs[3]));
  addsub_pipe #(.WIDTH(25), .SEGS(2)) u_p5 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .a(a_bus), .b(b_bus), .sub(sub), .scale(scale),
    .out(out4), .out_valid(ovs[4]));

  assign o_arr[0] = {1'b0, out0};
  assign o_arr[1] = {1'b0, out1};
  assign o_arr[2] = {1'b0, out2};
  assign o_arr[3] = {9'b0, out3};
  assign o_arr[4] = out4;

  // Integer reference: sign-extend, add or subtract, optional floor-halve.
  function automatic logic [25:0] golden(input int w, input logic [24:0] av,
                                         input logic [24:0] bv, input logic s,
                                         input logic sc);
    longint sa;
    longint sb;
    longint f;
    longint m;
    m  = longint'(1) << w;
    sa = longint'(av) & (m - 1);
    sb = longint'(bv) & (m - 1);
    if (sa >= m / 2) sa = sa - m;
    if (sb >= m / 2) sb = sb - m;
    f = s ? (sa - sb) : (sa + sb);
    if (sc) f = f >>> 1;
    return 26'(f & ((m << 1) - 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [24:0] av, input logic [24:0] bv,
                       input logic s, input logic sc, input logic v);
    a_bus    = av;
    b_bus    = bv;
    sub      = s;
    scale    = sc;
    in_valid = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    drive(25'h1, 25'h1, 1'b0, 1'b0, 1'b1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_arr[i] !== 26'h0) $display("FAIL reset_out[%0d]: got %h expected 0", i, o_arr[i]);
      else n_pass++;
      n_checks++;
      if (ovs[i] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b expected 0", i, ovs[i]);
      else n_pass++;
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ovs[0] !== 1'b0) $display("FAIL reset_release_valid: got %b expected 0", ovs[0]);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_basic_add();
    drive(25'h000001, 25'h000001, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (ovs[0] !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", ovs[0]);
    else n_pass++;
    step();
    n_checks++;
    if (ovs[0] !== 1'b1) $display("FAIL basic_valid: got %b expected 1", ovs[0]);
    else n_pass++;
    n_checks++;
    if (out0 !== 25'h0000002) $display("FAIL basic_out: got %h expected 0000002", out0);
    else n_pass++;
    step();
    n_checks++;
    if (ovs[0] !== 1'b0) $display("FAIL basic_valid_drop: got %b expected 0", ovs[0]);
    else n_pass++;
    $display("test_basic_add: 1+1 -> %h", 25'h0000002);
  endtask

  task automatic test_extremes();
    drive(25'h7FFFFF, 25'h000001, 1'b0, 1'b0, 1'b1);
    step();
    drive(25'h800000, 25'h000001, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (ovs[0] !== 1'b1 || out0 !== 25'h0800000)
      $display("FAIL pos_extreme: got v=%b %h expected v=1 0800000", ovs[0], out0);
    else n_pass++;
    step();
    n_checks++;
    if (ovs[0] !== 1'b1 || out0 !== 25'h17FFFFF)
      $display("FAIL neg_extreme: got v=%b %h expected v=1 17FFFFF", ovs[0], out0);
    else n_pass++;
    $display("test_extremes done");
  endtask

  task automatic test_seg_carry();
    logic [24:0] va [3];
    logic [24:0] vb [3];
    logic        vs [3];
    logic [24:0] ve [3];
    int idx;
    va = '{25'h000FFF, 25'h000000, 25'h000FFF};
    vb = '{25'h000001, 25'h000001, 25'h000FFF};
    vs = '{1'b0, 1'b1, 1'b1};
    ve = '{25'h0001000, 25'h1FFFFFF, 25'h0000000};
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(va[c], vb[c], vs[c], 1'b0, 1'b1);
      else in_valid = 1'b0;
      step();
      idx = c - 1;
      n_checks++;
      if (idx >= 0 && idx < 3) begin
        if (ovs[0] !== 1'b1 || out0 !== ve[idx])
          $display("FAIL seg_carry[%0d]: got v=%b %h expected v=1 %h", idx, ovs[0], out0, ve[idx]);
        else n_pass++;
      end else begin
        if (ovs[0] !== 1'b0) $display("FAIL seg_carry_idle: got v=%b expected 0", ovs[0]);
        else n_pass++;
      end
    end
    $display("test_seg_carry done");
  endtask

  task automatic test_scaling();
    logic [24:0] va [6];
    logic [24:0] vb [6];
    logic        vs [6];
    logic        vc [6];
    logic [24:0] ve [6];
    int idx;
    va = '{25'h000003, 25'hFFFFFD, 25'h000003, 25'h7FFFFF, 25'hFFFFFD, 25'h800000};
    vb = '{25'h000002, 25'h000000, 25'h000002, 25'h7FFFFF, 25'h000002, 25'h800000};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vc = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ve = '{25'h0000002, 25'h1FFFFFE, 25'h0000005, 25'h07FFFFF, 25'h1FFFFFD, 25'h1800000};
    for (int c = 0; c < 7; c++) begin
      if (c < 6) drive(va[c], vb[c], vs[c], vc[c], 1'b1);
      else in_valid = 1'b0;
      step();
      idx = c - 1;
      if (idx >= 0) begin
        n_checks++;
        if (ovs[0] !== 1'b1 || out0 !== ve[idx])
          $display("FAIL scale[%0d]: got v=%b %h expected v=1 %h", idx, ovs[0], out0, ve[idx]);
        else n_pass++;
      end
    end
    $display("test_scaling done");
  endtask

  task automatic test_stall();
    drive(25'd10, 25'd20, 1'b0, 1'b0, 1'b1);
    step();
    drive(25'd100, 25'd1, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if (ovs[0] !== 1'b1 || out0 !== 25'd30)
      $display("FAIL stall_pre: got v=%b %h expected v=1 %h", ovs[0], out0, 25'd30);
    else n_pass++;
    en = 1'b0;
    drive(25'd5, 25'd5, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (ovs[0] !== 1'b1 || out0 !== 25'd30)
        $display("FAIL stall_hold[%0d]: got v=%b %h expected v=1 %h", c, ovs[0], out0, 25'd30);
      else n_pass++;
    end
    en       = 1'b1;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ovs[0] !== 1'b1 || out0 !== 25'd99)
      $display("FAIL stall_resume: got v=%b %h expected v=1 %h", ovs[0], out0, 25'd99);
    else n_pass++;
    step();
    n_checks++;
    if (ovs[0] !== 1'b0) $display("FAIL stall_no_ghost: got v=%b expected 0", ovs[0]);
    else n_pass++;
    $display("test_stall done");
  endtask

  task automatic test_flush();
    drive(25'd1, 25'd2, 1'b0, 1'b0, 1'b1);
    step();
    drive(25'd3, 25'd4, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (ovs[0] !== 1'b0) $display("FAIL flush_run[%0d]: got v=%b expected 0", c, ovs[0]);
      else n_pass++;
      step();
    end
    drive(25'd9, 25'd9, 1'b0, 1'b0, 1'b1);
    step();
    en       = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b0;
    step();
    en    = 1'b1;
    flush = 1'b0;
    n_checks++;
    if (ovs[0] !== 1'b0) $display("FAIL flush_stalled_a: got v=%b expected 0", ovs[0]);
    else n_pass++;
    step();
    n_checks++;
    if (ovs[0] !== 1'b0) $display("FAIL flush_stalled_b: got v=%b expected 0", ovs[0]);
    else n_pass++;
    drive(25'd7, 25'd8, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ovs[0] !== 1'b1 || out0 !== 25'd15)
      $display("FAIL flush_recover: got v=%b %h expected v=1 %h", ovs[0], out0, 25'd15);
    else n_pass++;
    step();
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    drive(25'h123456, 25'h111111, 1'b0, 1'b0, 1'b1);
    step();
    drive(25'h000010, 25'h000020, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (ovs[0] !== 1'b1 || out0 !== 25'h0234567)
      $display("FAIL rstmid_pre: got v=%b %h expected v=1 0234567", ovs[0], out0);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ovs[0] !== 1'b0 || out0 !== 25'h0)
      $display("FAIL rstmid_async: got v=%b %h expected v=0 0", ovs[0], out0);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (ovs[0] !== 1'b0) $display("FAIL rstmid_stale[%0d]: got v=%b expected 0", c, ovs[0]);
      else n_pass++;
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_params_random();
    int idx;
    logic exp_v;
    logic [25:0] exp_o;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    flush = 1'b0;
    for (int t = 1; t <= 44; t++) begin
      if (t <= 40) begin
        h_a[t]  = 25'($urandom);
        h_b[t]  = 25'($urandom);
        h_s[t]  = 1'($urandom_range(1));
        h_sc[t] = 1'($urandom_range(1));
        h_v[t]  = ($urandom_range(3) != 0);
      end else begin
        h_a[t]  = '0;
        h_b[t]  = '0;
        h_s[t]  = 1'b0;
        h_sc[t] = 1'b0;
        h_v[t]  = 1'b0;
      end
      drive(h_a[t], h_b[t], h_s[t], h_sc[t], h_v[t]);
      step();
      for (int i = 0; i < 5; i++) begin
        idx   = t - lat[i] + 1;
        exp_v = (idx >= 1) ? h_v[idx] : 1'b0;
        n_checks++;
        if (ovs[i] !== exp_v)
          $display("FAIL rand_valid[%0d] t=%0d: got %b expected %b", i, t, ovs[i], exp_v);
        else n_pass++;
        if (exp_v) begin
          exp_o = golden(wd[i], h_a[idx], h_b[idx], h_s[idx], h_sc[idx]);
          n_checks++;
          if (o_arr[i] !== exp_o)
            $display("FAIL rand_out[%0d] t=%0d: got %h expected %h", i, t, o_arr[i], exp_o);
          else n_pass++;
        end
      end
    end
    $display("test_params_random done");
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_extremes();
    test_seg_carry();
    test_scaling();
    test_stall();
    test_flush();
    test_reset_mid();
    test_params_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
